demux2_tdm: RTL and testbench



---
 rtl/demux2_tdm.sv | 107 ++++++++++
 tb/tb_demux2_tdm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/demux2_tdm.sv
// Two-channel bit-interleaved TDM demultiplexer with frame-sync lock.
// Even slots feed channel 1 and odd slots feed channel 2, MSB first. Both words are presented together on frame completion.

module demux2_tdm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] word_nx
);
  logic [WIDTH-1:0] sr;

  // Value this lane will hold once the current bit has been taken in.
  assign word_nx = shift ? {sr[WIDTH-2:0], din} : sr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      sr <= '0;
    else if (restart)
      sr <= shift ? {{(WIDTH-1){1'b0}}, din} : '0;
    else if (shift)
      sr <= word_nx;
  end
endmodule

module demux2_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out_valid,
  output logic             locked,
  output logic             frame_err
);
  localparam int SLOTS = 2 * WIDTH;
  localparam int CW    = $clog2(SLOTS);
  localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

  typedef enum logic {UNLOCKED, RUN} state_t;

  state_t                     state;
  logic   [CW-1:0]            cnt;
  logic                       accept, restart, sel;
  logic   [1:0][WIDTH-1:0]    word_nx;

  assign accept  = in_valid && (state == RUN || sync);
  // A sync anywhere but slot 0 of a running frame starts a fresh frame.
  assign restart = in_valid && sync && (state == UNLOCKED || cnt != '0);
  assign sel     = restart ? 1'b0 : cnt[0];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    demux2_tdm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .shift   (accept && (sel == (g == 1))),
      .din     (in),
      .word_nx (word_nx[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      cnt       <= '0;
      out1      <= '0;
      out2      <= '0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid) begin
        case (state)
          UNLOCKED: if (sync) begin
            state  <= RUN;
            locked <= 1'b1;
            cnt    <= CW'(1);
          end
          RUN: begin
            if (restart) begin
              frame_err <= 1'b1;
              cnt       <= CW'(1);
            end else if (cnt == LAST) begin
              out1      <= word_nx[0];
              out2      <= word_nx[1];
              out_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_demux2_tdm.sv
// Randomised and directed bench for demux2_tdm with a queue-based frame model and a scoreboard.
module tb_demux2_tdm;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in = 1'b0, in_valid = 1'b0, sync = 1'b0;
  logic [W-1:0] out1, out2;
  logic         out_valid, locked, frame_err;

  demux2_tdm #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .sync(sync),
    .out1(out1), .out2(out2), .out_valid(out_valid), .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0] o1; logic [W-1:0] o2; int at; } exp_t;
  exp_t exp_q[$];
  int   err_q[$];

  // Reference model: collects the bits of the current frame and de-interleaves them when it is full.
  bit           m_locked;
  bit           m_bits[$];
  logic [W-1:0] m_o1, m_o2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_step(input bit b, input bit s);
    exp_t e;
    if (!m_locked) begin
      if (!s) return;
      m_locked = 1;
      m_bits.delete();
      m_bits.push_back(b);
      return;
    end
    if (s && m_bits.size() != 0) begin
      err_q.push_back(cyc + 1);
      m_bits.delete();
      m_bits.push_back(b);
      return;
    end
    m_bits.push_back(b);
    if (m_bits.size() == 2 * W) begin
      for (int i = 0; i < W; i++) begin
        m_o1[W-1-i] = m_bits[2*i];
        m_o2[W-1-i] = m_bits[2*i+1];
      end
      e.o1 = m_o1; e.o2 = m_o2; e.at = cyc + 1;
      exp_q.push_back(e);
      m_bits.delete();
    end
  endfunction

  // Drive one cycle; v=0 gives an idle gap (sync is still toggled to show it is ignored).
  task automatic drive(input bit b, input bit v, input bit s);
    @(posedge clk); #1;
    in = b; in_valid = v; sync = s;
    if (v) model_step(b, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; sync = 1'b0;
    m_locked = 0; m_bits.delete(); m_o1 = '0; m_o2 = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [2*W-1:0] f, input bit first_sync, input int gap_a, input int gap_b);
    for (int i = 0; i < 2 * W; i++) begin
      drive(f[2*W-1-i], 1'b1, first_sync && i == 0);
      if (i == 3) idle(gap_a);
      if (i == 10) idle(gap_b);
    end
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    chk({tag, " out1"}, 32'(out1), 32'(m_o1));
    chk({tag, " out2"}, 32'(out2), 32'(m_o2));
    chk({tag, " locked"}, 32'(locked), 32'(m_locked));
  endtask

  // Scoreboard monitor: every strobe must match the head of its expectation queue, on the predicted cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected out_valid", 32'(1), 32'(0));
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out1", 32'(out1), 32'(e.o1));
        chk("out2", 32'(out2), 32'(e.o2));
        chk("out_valid cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (rst_n && frame_err) begin
      if (err_q.size() == 0) chk("unexpected frame_err", 32'(1), 32'(0));
      else chk("frame_err cycle", 32'(cyc), 32'(err_q.pop_front()));
    end
  end

  localparam logic [2*W-1:0] BASIC = 16'h8D72;  // 1,0,0,0,1,1,0,1,0,1,1,1,0,0,1,0
  localparam logic [2*W-1:0] ALT   = 16'hAAAA;  // 1,0 x8 -> FF / 00

  initial begin
    m_locked = 0; m_o1 = '0; m_o2 = '0;
    do_reset(2);
    chk_state("reset");
    for (int i = 0; i < 5; i++) drive(1'($urandom), 1'b1, 1'b0);
    chk_state("no sync");

    send_frame(BASIC, 1'b1, 0, 0);
    idle(2);
    chk_state("basic");
    chk("basic word1", 32'(out1), 32'h A5);
    chk("basic word2", 32'(out2), 32'h 3C);

    send_frame(BASIC, 1'b1, 0, 0);
    send_frame(ALT, 1'b0, 0, 0);
    idle(2);
    chk("b2b word1", 32'(out1), 32'h FF);
    chk("b2b word2", 32'(out2), 32'h 00);

    send_frame(BASIC, 1'b1, 3, 3);
    idle(2);
    chk_state("gaps");

    for (int i = 0; i < 6; i++) drive(1'($urandom), 1'b1, i == 0);
    send_frame(ALT, 1'b1, 0, 0);
    idle(2);
    chk_state("mid sync");

    send_frame(BASIC, 1'b1, 0, 0);
    for (int i = 0; i < 6; i++) drive(1'($urandom), 1'b1, i == 0);
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("err hold out1", 32'(out1), 32'h A5);
    chk("err hold out2", 32'(out2), 32'h 3C);

    for (int i = 0; i < 9; i++) drive(1'($urandom), 1'b1, i == 0);
    do_reset(1);
    chk_state("mid reset");
    send_frame(ALT, 1'b1, 0, 0);
    idle(2);
    chk_state("after reset");

    for (int i = 0; i < 600; i++)
      drive(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(24) == 0));
    idle(4);
    chk_state("random");
    chk("pending words", 32'(exp_q.size()), 32'(0));
    chk("pending errs", 32'(err_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
